// File: rtl/ping_scheduler_if.sv
// Bundles the control, echo/trigger and result signals of the ping scheduler.
// The scheduler uses the slave modport; whatever drives enable/mask/echo uses master.
interface ping_scheduler_if #(
  parameter int NUM_SENSORS = 4,
  parameter int CNT_W       = 18
);
  logic                   enable;
  logic [NUM_SENSORS-1:0] sensor_mask;
  logic [NUM_SENSORS-1:0] echo;
  logic [NUM_SENSORS-1:0] trig;
  logic                   busy;
  logic                   result_valid;
  logic [2:0]             result_sensor;
  logic [CNT_W-1:0]       result_width;
  logic                   result_timeout;

  modport master (
    output enable, sensor_mask, echo,
    input  trig, busy, result_valid, result_sensor, result_width, result_timeout
  );

  modport slave (
    input  enable, sensor_mask, echo,
    output trig, busy, result_valid, result_sensor, result_width, result_timeout
  );
endinterface

// File: rtl/ping_scheduler.sv
// Round-robin ultrasonic ping sequencer: one transducer at a time, trigger,
// blanking, echo-width measurement with timeout, then a holdoff before the next ping.
module ping_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int CNT_W          = 18,
  parameter int TRIG_CYCLES    = 22,
  parameter int BLANK_CYCLES   = 30,
  parameter int TIMEOUT_CYCLES = 79000,
  parameter int HOLDOFF_CYCLES = 20800
) (
  input  logic             osc_clk,
  input  logic             stdby_in,
  ping_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    RESULT,
    HOLDOFF
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_T      = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0]       LAST_INIT    = 3'(NUM_SENSORS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       t_q, t_d;
  logic [CNT_W-1:0]       w_q, w_d;
  logic [2:0]             sel_q, sel_d;
  logic [2:0]             last_sel_q, last_sel_d;
  logic [2:0]             res_sensor_q, res_sensor_d;
  logic [CNT_W-1:0]       res_width_q, res_width_d;
  logic                   res_timeout_q, res_timeout_d;
  logic [NUM_SENSORS-1:0] echo_meta_q, echo_s_q, echo_d_q;

  logic [NUM_SENSORS-1:0] sel_onehot;
  logic                   rise, fall;
  logic [CNT_W-1:0]       t_inc, w_inc;
  logic [2:0]             next_sel;
  logic                   next_found;
  logic [4:0]             cand;
  logic [NUM_SENSORS-1:0] rot;

  assign sel_onehot = {{(NUM_SENSORS-1){1'b0}}, 1'b1} << sel_q;
  assign rise       = |(echo_s_q & ~echo_d_q & sel_onehot);
  assign fall       = |(~echo_s_q & echo_d_q & sel_onehot);
  assign t_inc      = (t_q == CNT_MAX) ? t_q : t_q + 1'b1;
  assign w_inc      = (w_q == CNT_MAX) ? w_q : w_q + 1'b1;

  // Search the mask cyclically, starting just after the last served sensor.
  always_comb begin
    next_sel   = last_sel_q;
    next_found = 1'b0;
    cand       = '0;
    rot        = '0;
    for (int i = 1; i <= NUM_SENSORS; i++) begin
      cand = {2'b00, last_sel_q} + 5'(i);
      if (cand >= 5'(NUM_SENSORS)) begin
        cand = cand - 5'(NUM_SENSORS);
      end
      rot = bus.sensor_mask >> cand;
      if (!next_found && rot[0]) begin
        next_found = 1'b1;
        next_sel   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    w_d           = w_q;
    sel_d         = sel_q;
    last_sel_d    = last_sel_q;
    res_sensor_d  = res_sensor_q;
    res_width_d   = res_width_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && next_found) begin
          sel_d   = next_sel;
          t_d     = '0;
          state_d = TRIG;
        end
      end
      TRIG: begin
        t_d = t_inc;
        if (t_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        t_d = t_inc;
        if (rise && (t_q >= BLANK_T)) begin
          w_d     = '0;
          state_d = MEASURE;
        end else if (t_q == TIMEOUT_LAST) begin
          res_sensor_d  = sel_q;
          res_width_d   = CNT_MAX;
          res_timeout_d = 1'b1;
          state_d       = RESULT;
        end
      end
      // A fall on the final allowed cycle still counts as a valid echo.
      MEASURE: begin
        w_d = w_inc;
        if (fall) begin
          res_sensor_d  = sel_q;
          res_width_d   = w_q + 1'b1;
          res_timeout_d = 1'b0;
          state_d       = RESULT;
        end else if (w_q == TIMEOUT_LAST) begin
          res_sensor_d  = sel_q;
          res_width_d   = CNT_MAX;
          res_timeout_d = 1'b1;
          state_d       = RESULT;
        end
      end
      RESULT: begin
        last_sel_d = sel_q;
        t_d        = '0;
        state_d    = HOLDOFF;
      end
      HOLDOFF: begin
        t_d = t_inc;
        if (t_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (stdby_in) begin
      state_q       <= IDLE;
      t_q           <= '0;
      w_q           <= '0;
      sel_q         <= '0;
      last_sel_q    <= LAST_INIT;
      res_sensor_q  <= '0;
      res_width_q   <= '0;
      res_timeout_q <= 1'b0;
      echo_meta_q   <= '0;
      echo_s_q      <= '0;
      echo_d_q      <= '0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      w_q           <= w_d;
      sel_q         <= sel_d;
      last_sel_q    <= last_sel_d;
      res_sensor_q  <= res_sensor_d;
      res_width_q   <= res_width_d;
      res_timeout_q <= res_timeout_d;
      echo_meta_q   <= bus.echo;
      echo_s_q      <= echo_meta_q;
      echo_d_q      <= echo_s_q;
    end
  end

  assign bus.trig           = (state_q == TRIG) ? sel_onehot : '0;
  assign bus.busy           = (state_q != IDLE);
  assign bus.result_valid   = (state_q == RESULT);
  assign bus.result_sensor  = res_sensor_q;
  assign bus.result_width   = res_width_q;
  assign bus.result_timeout = res_timeout_q;

endmodule

// File: doc/ping_scheduler.md
Name: ping_scheduler

Overview:
- Sequences up to NUM_SENSORS ultrasonic rangers that share one ping timeslot, so that only one transducer is active at any time and crosstalk is avoided.
- Selects sensors round-robin from an enable mask.
- For the selected sensor: issues the trigger pulse, blanks early echo, times the echo-high width, detects timeout, then holds off before the next ping.
- Delivers one tagged result per ping to downstream averaging/LED logic on the osc_clk (2.08 MHz) domain.

Parameters:
- NUM_SENSORS, 4, number of sensor channels (2..8).
- CNT_W, 18, width of cycle timer and result width.
- TRIG_CYCLES, 22, trig high duration in clocks (~10.6 us).
- BLANK_CYCLES, 30, clocks from trig start during which echo edges are ignored.
- TIMEOUT_CYCLES, 79000, max clocks from trig start to echo rise, and max echo-high width (~38 ms).
- HOLDOFF_CYCLES, 20800, idle clocks after each result before the next ping (~10 ms).

Ports:
- osc_clk  in  1  system clock, all logic on rising edge.
- stdby_in  in  1  synchronous active-high reset.
- enable  in  1  1 = start new pings; 0 = finish current ping, then stay idle.
- sensor_mask  in  NUM_SENSORS  per-sensor participation; sampled only in IDLE.
- echo  in  NUM_SENSORS  raw asynchronous echo lines.
- trig  out  NUM_SENSORS  trigger outputs, at most one bit high.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse per completed ping.
- result_sensor  out  3  index of the sensor for this result.
- result_width  out  CNT_W  echo-high width in clocks; all-ones on timeout.
- result_timeout  out  1  qualifies result_valid; 1 = no echo or echo too long.

Behaviour:
- Clock and reset: one clock, osc_clk. Reset is stdby_in, synchronous and active-high.
- Reset values:
  - All outputs 0; state = IDLE.
  - Timers 0; synchronizer flops 0.
  - last_sel = NUM_SENSORS-1, so the first ping after reset goes to sensor 0.
- stdby_in asserted mid-ping: trig drops and state is cleared on the same edge. No result_valid is issued for the aborted ping.
- echo is synchronized per bit with 2 flops (echo_s), plus one delay flop (echo_d).
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
  - Only the bit for the selected sensor (sel) is used.
- Timer t (CNT_W bits) saturates at all-ones; it never wraps.
- States:
  - IDLE:
    - If enable=1 and sensor_mask!=0: sel = first set mask bit strictly after last_sel, cyclic. Set t=0, go to TRIG.
    - Otherwise stay.
    - If mask has a single bit, that sensor is reselected every ping.
  - TRIG:
    - trig[sel]=1; t increments each cycle.
    - When t = TRIG_CYCLES-1: go to WAIT_RISE. trig is high for exactly TRIG_CYCLES clocks.
  - WAIT_RISE:
    - t continues to increment.
    - rise with t >= BLANK_CYCLES: width w=0, go to MEASURE.
    - rise with t < BLANK_CYCLES: ignored.
    - t = TIMEOUT_CYCLES-1 with no qualifying rise: emit timeout result.
  - MEASURE:
    - w increments each cycle.
    - fall: emit result with result_width = w+1 (count of clocks echo_s was high).
    - w reaches TIMEOUT_CYCLES-1 before fall: emit timeout result.
    - If fall and timeout occur on the same cycle, fall wins (normal result).
  - RESULT (one cycle):
    - result_valid=1; result_sensor=sel.
    - result_width = width, or all-ones if timeout; result_timeout set if timeout.
    - last_sel=sel; t=0; go to HOLDOFF.
    - result_sensor/width/timeout hold their values until the next RESULT.
  - HOLDOFF:
    - t increments; when t = HOLDOFF_CYCLES-1, go to IDLE.
    - Echo edges are ignored.
- enable or sensor_mask changes outside IDLE take effect only at the next IDLE evaluation. An in-flight ping always completes.
- Latency:
  - Minimum trig start to result_valid = BLANK_CYCLES + 1 (width) + 3 (sync+edge) + 1 clocks.
  - Back-to-back pings are spaced by at least HOLDOFF_CYCLES + 1 clocks of idle trig.

Test Plan:
Bench parameters: TRIG_CYCLES=22, BLANK_CYCLES=30, TIMEOUT_CYCLES=1000, HOLDOFF_CYCLES=50, NUM_SENSORS=4.
1. Reset, mask=4'b1111, enable=1 -> trig[0] high exactly 22 clocks. Echo[0] high at clock 100 for 200 clocks -> result_valid once, sensor=0, width=200, timeout=0. Next ping is to sensor 1 no sooner than 50 clocks later.
2. Round-robin with mask=4'b1010 -> ping order is 1,3,1,3. Changing mask to 4'b0100 during a MEASURE on sensor 3 -> the current ping completes, and the next ping is sensor 2.
3. Echo pulse at clock 10 (within blanking) -> ignored. Second echo at clock 60 lasting 40 clocks -> width=40. No echo at all -> result at t=999 with timeout=1 and width=all-ones.
4. Echo held high for >1000 clocks -> timeout=1, width all-ones. Echo falling on the same cycle that w reaches 999 -> timeout=0, width=1000.
5. stdby_in pulsed for 1 cycle during TRIG and during MEASURE -> trig low on that edge, no result_valid. Restart pings sensor 0.
6. enable dropped mid-ping -> that ping's result still appears, then busy=0 after holdoff, with no further trig. mask=0 with enable=1 -> stays IDLE, trig=0.
